// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and controller state encoding.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_t;

endpackage

// File: rtl/ahb_strb_gen.sv
// Byte-lane strobes plus alignment and size checks for one address phase.
module ahb_strb_gen #(
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [LANE_W-1:0] addr_lo,
  input  logic [2:0]        size,
  output logic [STRB_W-1:0] strb,
  output logic              misaligned,
  output logic              oversize
);

  logic [31:0] off;
  logic [31:0] nbytes;

  always_comb begin
    off        = {{(32-LANE_W){1'b0}}, addr_lo};
    nbytes     = 32'd1 << size;
    misaligned = (off & (nbytes - 32'd1)) != 32'd0;
    oversize   = (nbytes << 3) > 32'(DATA_W);
    strb       = '0;
    for (int i = 0; i < STRB_W; i++) begin
      strb[i] = (32'(i) >= off) && (32'(i) < off + nbytes);
    end
  end

endmodule

// File: rtl/ahb_slave_ctrl_v2.sv
// AHB-Lite slave front end: address-phase capture, wait/timeout FSM,
// two-cycle ERROR response and register-file handshake.
module ahb_slave_ctrl_v2
  import ahb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic [ADDR_W-1:0]   HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [DATA_W-1:0]   HWDATA,
  input  logic                HREADY,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [DATA_W-1:0]   HRDATA,
  output logic                reg_valid,
  output logic                reg_write,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic [2:0]          reg_size,
  output logic [DATA_W/8-1:0] reg_strb,
  output logic [DATA_W-1:0]   reg_wdata,
  input  logic [DATA_W-1:0]   reg_rdata,
  input  logic                reg_ready,
  input  logic                reg_error
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  wait_cnt;
  logic [STRB_W-1:0] strb_nx;
  logic              misaligned, oversize;
  logic              sel, ok_done, can_accept;
  logic              accept, dec_err;

  ahb_strb_gen #(
    .DATA_W (DATA_W)
  ) u_strb (
    .addr_lo    (HADDR[LANE_W-1:0]),
    .size       (HSIZE),
    .strb       (strb_nx),
    .misaligned (misaligned),
    .oversize   (oversize)
  );

  assign sel = HSEL & HREADY &
               ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign ok_done    = (state == DATA) & reg_ready & ~reg_error;
  assign can_accept = (state == IDLE) | (state == ERR2) | ok_done;
  assign accept     = can_accept & sel;
  assign dec_err    = misaligned | oversize;

  assign reg_valid = (state == DATA);
  assign reg_wdata = reg_valid ? HWDATA : '0;
  assign HRDATA    = (ok_done & ~reg_write) ? reg_rdata : '0;

  always_comb begin
    state_nx  = state;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    unique case (state)
      IDLE, ERR2: begin
        if (state == ERR2) HRESP = HRESP_ERROR;
        if (accept) state_nx = dec_err ? ERR1 : DATA;
        else        state_nx = IDLE;
      end
      DATA: begin
        HREADYOUT = ok_done;
        if (reg_ready) begin
          if (reg_error)   state_nx = ERR1;
          else if (accept) state_nx = dec_err ? ERR1 : DATA;
          else             state_nx = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = ERR1;
        end
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_nx  = ERR2;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept)
        wait_cnt <= '0;
      else if (reg_valid & ~reg_ready)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Decode-error phases never reach the register file, so keep the old bundle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      reg_write <= 1'b0;
      reg_addr  <= '0;
      reg_size  <= '0;
      reg_strb  <= '0;
    end else if (accept & ~dec_err) begin
      reg_write <= HWRITE;
      reg_addr  <= HADDR;
      reg_size  <= HSIZE;
      reg_strb  <= strb_nx;
    end
  end

endmodule
